decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32/RV64 instruction-decode pipeline stage with valid/ready handshakes on both sides and a 2-entry skid buffer.
- Sits between fetch and register-read/execute.
- Splits instruction fields, classifies type, generates the sign-extended immediate, flags illegal encodings and reports register usage.
- Supports pipeline flush.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64; immediate sign-extended to XLEN.
- PC_W, 32, width of the PC tag carried alongside each instruction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- flush  in  1  discard all held entries; block acceptance this cycle.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  PC_W  PC tag.
- out_opcode  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_funct3  out  3  instr[14:12].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_funct7  out  7  instr[31:25].
- out_type  out  6  one-hot {J,U,B,S,I,R}; all zero when illegal.
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type and illegal.
- out_illegal  out  1  unrecognised encoding.
- out_rs1_used  out  1  rs1 read: R, I, S, B.
- out_rs2_used  out  1  rs2 read: R, S, B.
- out_rd_written  out  1  rd written: R, I, U, J, and rd != 0.

Behaviour:
- Transfer rules:
  - accept = in_valid & in_ready & !flush.
  - Output transfer = out_valid & out_ready.
- Storage: main register (drives outputs) plus skid register.
  - in_ready is a register output: in_ready = !skid_valid. It never depends combinationally on out_ready.
- States:
  - EMPTY (no entry valid).
  - ONE (main valid).
  - TWO (main and skid valid).
- Transitions:
  - EMPTY + accept -> ONE; the entry appears on outputs the next cycle (latency 1).
  - ONE, accept & transfer -> ONE, main loaded with the new entry.
  - ONE, accept & !transfer -> TWO, new entry goes to skid.
  - ONE, !accept & transfer -> EMPTY.
  - TWO, transfer -> ONE, skid moves to main. No accept is possible in TWO because in_ready = 0.
- Order: strictly FIFO; no entry is dropped or duplicated.
- Decode happens combinationally on in_instr before capture. Outputs are pure register outputs with no input-to-output combinational path.
- Opcode map, held in the package:
  - R 0110011.
  - I: 0010011, 0000011 (load), 1100111 (JALR).
  - S 0100011.
  - B 1100011.
  - U: 0110111, 0010111.
  - J 1101111.
  - Any other opcode -> out_illegal = 1, out_type = 0, imm = 0, all *_used/written = 0.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Field outputs (rd, rs1, rs2, funct3, funct7) are passed through raw for every type, including illegal.
- Flush: at the next edge main_valid = skid_valid = 0. A simultaneous in_valid is not accepted. A simultaneous output transfer still counts downstream; the stage state is EMPTY afterwards.
- Reset, async assert at any time, including mid-transfer:
  - All valids 0; in_ready 1.
  - Every data output 0; out_type 0; out_illegal 0.
  - Held entries are discarded.
  - Deassertion takes effect at the next clk edge.

Decomposition:
- Package instruction_types holds:
  - Opcode constants R_TYPE, I_TYPE, LOAD, JALR, S_TYPE, B_TYPE, LUI, AUIPC, J_TYPE.
  - Typedef decoded_t (struct of all out_* fields except valid), used for both storage registers.
  - Enum for the ONE-HOT type bit positions.
- Sub-module decode_comb: purely combinational 32-bit instruction -> decoded_t, parameterised by XLEN. It is instantiated once on in_instr. decode_stage itself owns the skid/handshake logic.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready = 1 -> one cycle later: out_valid = 1, type = I, rd = 1, rs1 = 0, imm = 0x00000005, rs2_used = 0, rd_written = 1.
- SW x2,-4(x1) (0xFE20AE23) -> type = S, rs1 = 1, rs2 = 2, imm = 0xFFFFFFFC, rd_written = 0. With XLEN = 64: imm = 0xFFFFFFFFFFFFFFFC.
- LUI x5,0x12345 (0x123452B7) -> type = U, rd = 5, imm = 0x12345000, rs1_used = 0.
- 0x00000000 -> out_illegal = 1, type = 0, imm = 0, all *_used/written = 0.
- Backpressure: hold out_ready = 0 and offer 3 back-to-back instructions.
  - Required: 2 accepted; in_ready = 0 from the cycle after the second accept.
  - Release out_ready: outputs drain in order with no loss, and the third instruction is then accepted.
- Flush and reset: with 2 entries held, pulse flush -> out_valid = 0 and in_ready = 1 next cycle, and the in_valid offered that cycle is not accepted. Repeat the fill, then assert reset between edges -> outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/instruction_types.sv
// Shared decode definitions: opcode map, one-hot type
// bit positions and the decoded entry held by the stage.
package instruction_types;

    localparam int XLEN_MAX = 64;
    localparam int PC_MAX   = 64;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] S_TYPE = 7'b0100011;
    localparam logic [6:0] B_TYPE = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] J_TYPE = 7'b1101111;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } type_bit_e;

    // pc/imm sized for the widest build; the stage slices them
    typedef struct packed {
        logic [PC_MAX-1:0]   pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        logic [5:0]          typ;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
        logic                rs1_used;
        logic                rs2_used;
        logic                rd_written;
    } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV instruction decoder: fields, type,
// sign-extended immediate, illegal flag and register usage.
module decode_comb
    import instruction_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0]      op;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic [5:0]      typ;

    assign op    = instr[6:0];
    assign imm_x = XLEN'(signed'(imm32));

    // classify opcode and build the 32-bit immediate
    always_comb begin
        typ   = '0;
        imm32 = '0;
        unique case (1'b1)
            op == R_TYPE: begin
                typ[TYPE_R] = 1'b1;
            end
            op == I_TYPE, op == LOAD, op == JALR: begin
                typ[TYPE_I] = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            op == S_TYPE: begin
                typ[TYPE_S] = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:25],
                         instr[11:7]};
            end
            op == B_TYPE: begin
                typ[TYPE_B] = 1'b1;
                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
            end
            op == LUI, op == AUIPC: begin
                typ[TYPE_U] = 1'b1;
                imm32 = {instr[31:12], 12'b0};
            end
            op == J_TYPE: begin
                typ[TYPE_J] = 1'b1;
                imm32 = {{11{instr[31]}}, instr[31],
                         instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            default: begin
                typ   = '0;
                imm32 = '0;
            end
        endcase
    end

    // pack fields and usage flags into the decoded entry
    always_comb begin
        dec                = '0;
        dec.opcode         = op;
        dec.rd             = instr[11:7];
        dec.funct3         = instr[14:12];
        dec.rs1            = instr[19:15];
        dec.rs2            = instr[24:20];
        dec.funct7         = instr[31:25];
        dec.typ            = typ;
        dec.imm[XLEN-1:0]  = imm_x;
        dec.illegal        = (typ == 6'b0);
        dec.rs1_used       = typ[TYPE_R] | typ[TYPE_I]
                           | typ[TYPE_S] | typ[TYPE_B];
        dec.rs2_used       = typ[TYPE_R] | typ[TYPE_S]
                           | typ[TYPE_B];
        dec.rd_written     = (typ[TYPE_R] | typ[TYPE_I]
                           | typ[TYPE_U] | typ[TYPE_J])
                           & (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides
// and a two-entry (main + skid) buffer.
module decode_stage
    import instruction_types::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [5:0]      out_type,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal,
    output logic            out_rs1_used,
    output logic            out_rs2_used,
    output logic            out_rd_written
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e   state_q, state_d;
    decoded_t dec, in_dec, main_q, skid_q;
    logic     accept, xfer;
    logic     load_main, load_skid, skid_to_main;
    logic     unused_hi;

    decode_comb #(.XLEN(XLEN)) u_dec (
        .instr (in_instr),
        .dec   (dec)
    );

    // attach the PC tag to the freshly decoded entry
    always_comb begin
        in_dec    = dec;
        in_dec.pc = PC_MAX'(in_pc);
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign xfer      = out_valid & out_ready;

    // occupancy FSM: next state and buffer moves
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (xfer) begin
                        state_d   = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        state_d      = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // main/skid data registers; reset clears the outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)         main_q <= in_dec;
            else if (skid_to_main) main_q <= skid_q;
            if (load_skid)         skid_q <= in_dec;
        end
    end

    assign out_pc         = main_q.pc[PC_W-1:0];
    assign out_opcode     = main_q.opcode;
    assign out_rd         = main_q.rd;
    assign out_funct3     = main_q.funct3;
    assign out_rs1        = main_q.rs1;
    assign out_rs2        = main_q.rs2;
    assign out_funct7     = main_q.funct7;
    assign out_type       = main_q.typ;
    assign out_imm        = main_q.imm[XLEN-1:0];
    assign out_illegal    = main_q.illegal;
    assign out_rs1_used   = main_q.rs1_used;
    assign out_rs2_used   = main_q.rs2_used;
    assign out_rd_written = main_q.rd_written;

    // upper pc/imm bits above the configured widths
    assign unused_hi = ^{main_q.imm, main_q.pc};

endmodule

// File: tb/tb_decode_stage.sv
// Directed + scoreboard bench for decode_stage (XLEN 32
// and a lockstep XLEN 64 copy for immediate width).
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [5:0]  out_type;
    logic [31:0] out_imm;
    logic        out_illegal;
    logic        out_rs1_used;
    logic        out_rs2_used;
    logic        out_rd_written;

    logic        w_in_ready, w_out_valid;
    logic [31:0] w_pc;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [5:0]  w_type;
    logic [63:0] w_imm;
    logic        w_ill, w_r1u, w_r2u, w_rdw;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct7(out_funct7), .out_type(out_type),
        .out_imm(out_imm), .out_illegal(out_illegal),
        .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used),
        .out_rd_written(out_rd_written)
    );

    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_pc), .out_opcode(w_opcode),
        .out_rd(w_rd), .out_funct3(w_funct3),
        .out_rs1(w_rs1), .out_rs2(w_rs2),
        .out_funct7(w_funct7), .out_type(w_type),
        .out_imm(w_imm), .out_illegal(w_ill),
        .out_rs1_used(w_r1u), .out_rs2_used(w_r2u),
        .out_rd_written(w_rdw)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  typ;
        logic [63:0] imm;
        logic        illegal;
        logic        r1u;
        logic        r2u;
        logic        rdw;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    bit   acc_seen;

    function automatic exp_t model(logic [31:0] i,
                                   logic [31:0] pc);
        exp_t        e;
        logic [5:0]  t;
        logic [63:0] v;
        t = '0;
        v = '0;
        case (i[6:0])
            7'h33: t = 6'b000001;
            7'h13, 7'h03, 7'h67: begin
                t = 6'b000010;
                v = {{52{i[31]}}, i[31:20]};
            end
            7'h23: begin
                t = 6'b000100;
                v = {{52{i[31]}}, i[31:25], i[11:7]};
            end
            7'h63: begin
                t = 6'b001000;
                v = {{51{i[31]}}, i[31], i[7], i[30:25],
                     i[11:8], 1'b0};
            end
            7'h37, 7'h17: begin
                t = 6'b010000;
                v = {{32{i[31]}}, i[31:12], 12'b0};
            end
            7'h6f: begin
                t = 6'b100000;
                v = {{43{i[31]}}, i[31], i[19:12], i[20],
                     i[30:21], 1'b0};
            end
            default: ;
        endcase
        e.pc      = pc;
        e.instr   = i;
        e.typ     = t;
        e.imm     = v;
        e.illegal = (t == 6'b0);
        e.r1u     = t[0] | t[1] | t[2] | t[3];
        e.r2u     = t[0] | t[2] | t[3];
        e.rdw     = (t[0] | t[1] | t[4] | t[5])
                    && (i[11:7] != 5'd0);
        return e;
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("pc", 64'(out_pc), 64'(e.pc));
        chk("opcode", 64'(out_opcode), 64'(e.instr[6:0]));
        chk("rd", 64'(out_rd), 64'(e.instr[11:7]));
        chk("funct3", 64'(out_funct3), 64'(e.instr[14:12]));
        chk("rs1", 64'(out_rs1), 64'(e.instr[19:15]));
        chk("rs2", 64'(out_rs2), 64'(e.instr[24:20]));
        chk("funct7", 64'(out_funct7), 64'(e.instr[31:25]));
        chk("type", 64'(out_type), 64'(e.typ));
        chk("imm32", 64'(out_imm), 64'(e.imm[31:0]));
        chk("imm64", w_imm, e.imm);
        chk("illegal", 64'(out_illegal), 64'(e.illegal));
        chk("rs1_used", 64'(out_rs1_used), 64'(e.r1u));
        chk("rs2_used", 64'(out_rs2_used), 64'(e.r2u));
        chk("rd_written", 64'(out_rd_written), 64'(e.rdw));
    endtask

    // monitor at negedge, then advance to just past posedge
    task automatic cycle();
        exp_t e;
        acc_seen = 1'b0;
        @(negedge clk);
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_underflow", 64'(sb.size() == 0), 64'd0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    compare(e);
                    popped++;
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready && !flush) begin
                sb.push_back(model(in_instr, in_pc));
                acc_seen = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i,
                        input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = pc;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        int n;
        int p0;

        // reset state
        cycle();
        cycle();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_type", 64'(out_type), 64'd0);
        chk("rst_illegal", 64'(out_illegal), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        reset = 1'b0;
        cycle();
        out_ready = 1'b1;

        // ADDI x1,x0,5
        send(32'h00500093, 32'h100);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_type", 64'(out_type), 64'h02);
        chk("addi_rd", 64'(out_rd), 64'd1);
        chk("addi_rs1", 64'(out_rs1), 64'd0);
        chk("addi_imm", 64'(out_imm), 64'h5);
        chk("addi_rs2u", 64'(out_rs2_used), 64'd0);
        chk("addi_rdw", 64'(out_rd_written), 64'd1);
        cycle();

        // SW x2,-4(x1)
        send(32'hFE20AE23, 32'h104);
        chk("sw_type", 64'(out_type), 64'h04);
        chk("sw_rs1", 64'(out_rs1), 64'd1);
        chk("sw_rs2", 64'(out_rs2), 64'd2);
        chk("sw_imm", 64'(out_imm), 64'hFFFFFFFC);
        chk("sw_imm64", w_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("sw_rdw", 64'(out_rd_written), 64'd0);
        cycle();

        // LUI x5,0x12345
        send(32'h123452B7, 32'h108);
        chk("lui_type", 64'(out_type), 64'h10);
        chk("lui_rd", 64'(out_rd), 64'd5);
        chk("lui_imm", 64'(out_imm), 64'h12345000);
        chk("lui_rs1u", 64'(out_rs1_used), 64'd0);
        cycle();

        // all-zero word is illegal
        send(32'h00000000, 32'h10C);
        chk("ill_flag", 64'(out_illegal), 64'd1);
        chk("ill_type", 64'(out_type), 64'd0);
        chk("ill_imm", 64'(out_imm), 64'd0);
        chk("ill_used",
            64'({out_rs1_used, out_rs2_used, out_rd_written}),
            64'd0);
        cycle();

        // more encodings via scoreboard only
        send(32'hFE000EE3, 32'h110);
        send(32'h800000EF, 32'h114);
        send(32'h000080E7, 32'h118);
        send(32'hFFFFF017, 32'h11C);
        send(32'h40208033, 32'h120);
        send(32'hFFF0B003, 32'h124);
        drain(10);

        // backpressure: three offers, two accepted
        out_ready = 1'b0;
        send(32'h00100113, 32'h200);
        chk("bp_ready1", 64'(in_ready), 64'd1);
        send(32'h00200193, 32'h204);
        chk("bp_ready2", 64'(in_ready), 64'd0);
        p0 = popped;
        send(32'h00300213, 32'h208);
        chk("bp_third_rej", 64'(acc_seen), 64'd0);
        chk("bp_ready3", 64'(in_ready), 64'd0);
        chk("bp_head_pc", 64'(out_pc), 64'h200);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (in_valid && n < 10) begin
            cycle();
            if (acc_seen) in_valid = 1'b0;
            n++;
        end
        chk("bp_third_acc", 64'(in_valid), 64'd0);
        drain(10);
        chk("bp_count", 64'(popped - p0), 64'd3);

        // random traffic
        for (int k = 0; k < 200; k++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = rand_instr();
            in_pc     = 32'h1000 + 32'(k * 4);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(10);

        // flush with two entries held
        out_ready = 1'b0;
        send(32'h00500293, 32'h300);
        send(32'h00600313, 32'h304);
        chk("fl_full", 64'(in_ready), 64'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00700393;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd1);
        chk("fl_sb", 64'(sb.size()), 64'd0);
        out_ready = 1'b1;
        cycle();
        cycle();
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // async reset with two entries held
        out_ready = 1'b0;
        send(32'h00800413, 32'h400);
        send(32'hFFF00493, 32'h404);
        chk("ar_full", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        chk("ar_imm", 64'(out_imm), 64'd0);
        chk("ar_pc", 64'(out_pc), 64'd0);
        chk("ar_type", 64'(out_type), 64'd0);
        cycle();
        reset     = 1'b0;
        out_ready = 1'b1;
        cycle();
        send(32'h00A00513, 32'h500);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
